ysyx_2022040010_shift_seq: RTL and testbench

Multi-cycle, area-reduced shift unit for the RV64 execute stage. It is the sequential, handshaked counterpart of the single-cycle combinational shifter. The ALU issues a shift request over a valid/ready interface. The block applies one binary shift stage per clock (32, 16, 8, 4, 2, 1) and returns the result over a second valid/ready interface. It supports SLL/SRL/SRA and the RV64 word forms (SLLW/SRLW/SRAW).

---
 rtl/ysyx_2022040010_shift_seq_pkg.sv | 19 +
 rtl/ysyx_2022040010_shift_stage.sv | 25 ++
 rtl/ysyx_2022040010_shift_seq.sv | 119 +++++++++++
 tb/tb_ysyx_2022040010_shift_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_2022040010_shift_seq_pkg.sv
// Shared constants for the sequential RV64 shifter: op-select bits, FSM encodings, step counts.
package ysyx_2022040010_shift_seq_pkg;

  localparam int OP_SLL_BIT = 2;
  localparam int OP_SRL_BIT = 1;
  localparam int OP_SRA_BIT = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] STEPS_64 = 3'd6;
  localparam logic [2:0] STEPS_32 = 3'd5;

  function automatic logic [63:0] sext_word(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

endpackage

// File: rtl/ysyx_2022040010_shift_stage.sv
// One binary shift stage: shifts by 2**stage_idx when enabled, right shifts fill with the fill bit.
module ysyx_2022040010_shift_stage (
  input  logic [63:0] value,
  input  logic        enable,
  input  logic        shift_left,
  input  logic        fill,
  input  logic [2:0]  stage_idx,
  output logic [63:0] result
);

  logic [6:0]  sh;
  logic [63:0] fill_mask;

  always_comb begin
    sh        = 7'd1 << stage_idx;
    fill_mask = fill ? ~({64{1'b1}} >> sh) : 64'd0;
    if (!enable)
      result = value;
    else if (shift_left)
      result = value << sh;
    else
      result = (value >> sh) | fill_mask;
  end

endmodule

// File: rtl/ysyx_2022040010_shift_seq.sv
// Multi-cycle handshaked shifter: one binary stage per clock, counting the stage index down.
//   state | meaning
//   IDLE  | waiting for a request, in_ready=1
//   BUSY  | applying one shift stage per edge, step counter counts down
//   DONE  | result registered, out_valid=1 until out_ready
module ysyx_2022040010_shift_seq
  import ysyx_2022040010_shift_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] shift_operand,
  input  logic [XLEN-1:0] shift_amount,
  input  logic [2:0]      shift_op,
  input  logic            alu_32,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] shift_result
);

  logic [1:0]      state;
  logic [XLEN-1:0] work;
  logic [5:0]      amt_r;
  logic            fill_r;
  logic            left_r;
  logic            word_r;
  logic [2:0]      step_cnt;

  logic            op_sll, op_srl, op_sra, op_none;
  logic [XLEN-1:0] init_val;
  logic [5:0]      init_amt;
  logic [2:0]      stage_idx;
  logic            stage_en;
  logic [XLEN-1:0] stage_out;
  logic            accept;
  logic            amount_unused;

  assign amount_unused = ^shift_amount[XLEN-1:6];

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready & ~flush;

  // Priority decode of the one-hot-ish op select: SLL beats SRL beats SRA.
  assign op_sll  = shift_op[OP_SLL_BIT];
  assign op_srl  = ~op_sll & shift_op[OP_SRL_BIT];
  assign op_sra  = ~op_sll & ~op_srl & shift_op[OP_SRA_BIT];
  assign op_none = ~(op_sll | op_srl | op_sra);

  always_comb begin
    if (op_none)
      init_val = '0;
    else if (alu_32)
      init_val = op_sra ? sext_word(shift_operand[31:0]) : {32'd0, shift_operand[31:0]};
    else
      init_val = shift_operand;
    init_amt = alu_32 ? {1'b0, shift_amount[4:0]} : shift_amount[5:0];
  end

  // Counter value N selects stage 2**(N-1), so a word op starting at 5 skips the 32 stage.
  assign stage_idx = step_cnt - 3'd1;
  assign stage_en  = |(amt_r & (6'd1 << stage_idx));

  ysyx_2022040010_shift_stage u_stage (
    .value      (work),
    .enable     (stage_en),
    .shift_left (left_r),
    .fill       (fill_r),
    .stage_idx  (stage_idx),
    .result     (stage_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      work         <= '0;
      amt_r        <= '0;
      fill_r       <= 1'b0;
      left_r       <= 1'b0;
      word_r       <= 1'b0;
      step_cnt     <= '0;
      shift_result <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_BUSY;
            work     <= init_val;
            amt_r    <= init_amt;
            fill_r   <= op_sra & init_val[XLEN-1];
            left_r   <= op_sll;
            word_r   <= alu_32;
            step_cnt <= alu_32 ? STEPS_32 : STEPS_64;
          end
        end
        ST_BUSY: begin
          work     <= stage_out;
          step_cnt <= step_cnt - 3'd1;
          if (step_cnt == 3'd1) begin
            state        <= ST_DONE;
            shift_result <= word_r ? sext_word(stage_out[31:0]) : stage_out;
          end
        end
        ST_DONE: begin
          if (out_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_shift_seq.sv
// Scoreboard bench for the sequential shifter: latency, results, backpressure, flush and reset.
module tb_ysyx_2022040010_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] shift_operand;
  logic [63:0] shift_amount;
  logic [2:0]  shift_op;
  logic        alu_32;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] shift_result;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ysyx_2022040010_shift_seq #(.XLEN(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .shift_operand (shift_operand),
    .shift_amount  (shift_amount),
    .shift_op      (shift_op),
    .alu_32        (alu_32),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .shift_result  (shift_result)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0]        x;
    logic signed [63:0] s64;
    logic signed [31:0] s32;
    int                 sh;
    sh = w ? int'(b[4:0]) : int'(b[5:0]);
    if (op[2])
      x = (w ? {32'd0, a[31:0]} : a) << sh;
    else if (op[1])
      x = (w ? {32'd0, a[31:0]} : a) >> sh;
    else if (op[0]) begin
      if (w) begin
        s32 = a[31:0];
        s32 = s32 >>> sh;
        x   = {{32{s32[31]}}, s32};
      end else begin
        s64 = a;
        x   = s64 >>> sh;
      end
    end else
      x = 64'd0;
    return w ? {{32{x[31]}}, x[31:0]} : x;
  endfunction

  // Drive one request, check fixed latency, optionally hold backpressure, then pop and compare.
  task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int hold);
    int          cyc;
    logic [63:0] want;
    logic [63:0] held;
    @(negedge clk);
    check_val({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; shift_op = op; alu_32 = w; shift_operand = a; shift_amount = b;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val({tag, "_latency"}, 64'(cyc), w ? 64'd5 : 64'd6);
    want = exp_q.pop_front();
    check_val({tag, "_result"}, shift_result, want);
    held = shift_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_val({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check_val({tag, "_hold_result"}, shift_result, held);
      check_val({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    check_val({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic start_req(input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in_valid = 1'b1; shift_op = 3'b100; alu_32 = 1'b0; shift_operand = a; shift_amount = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_val({tag, "_no_valid"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [2:0]  ops [6] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b110, 3'b011};
    logic [2:0]  rop;
    logic        rw;
    logic [63:0] ra, rb;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    shift_operand = '0; shift_amount = '0; shift_op = '0; alu_32 = 1'b0;
    #1;
    check_val("reset_in_ready", 64'(in_ready), 64'd1);
    check_val("reset_out_valid", 64'(out_valid), 64'd0);
    check_val("reset_result", shift_result, 64'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    run_op("sll63", 3'b100, 1'b0, 64'h1, 64'd63, 64'h8000000000000000, 0);
    run_op("sra4", 3'b001, 1'b0, 64'h8000000000000000, 64'd4, 64'hF800000000000000, 0);
    run_op("srl4", 3'b010, 1'b0, 64'h8000000000000000, 64'd4, 64'h0800000000000000, 0);
    run_op("sraw31", 3'b001, 1'b1, 64'h0000000080000000, 64'd31, 64'hFFFFFFFFFFFFFFFF, 0);
    run_op("srlw4", 3'b010, 1'b1, 64'hFFFFFFFF80000000, 64'd4, 64'h0000000008000000, 0);
    run_op("sll_mask", 3'b100, 1'b0, 64'd3, 64'h41, 64'd6, 0);
    run_op("sllw_mask", 3'b100, 1'b1, 64'd1, 64'h21, 64'd2, 0);
    run_op("nop", 3'b000, 1'b0, 64'hDEADBEEF12345678, 64'd5, 64'd0, 0);
    run_op("sllw_sext", 3'b100, 1'b1, 64'h00000000_00000001, 64'd31, 64'hFFFFFFFF80000000, 0);
    run_op("backpressure", 3'b001, 1'b0, 64'h8123456789ABCDEF, 64'd12, 64'hFFF8123456789ABC, 10);
    run_op("after_bp", 3'b010, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd63, 64'd1, 0);

    for (int i = 0; i < 16; i++) begin
      rop = ops[$urandom_range(0, 5)];
      rw  = 1'($urandom_range(0, 1));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      run_op($sformatf("rand%0d", i), rop, rw, ra, rb, model(rop, rw, ra, rb), 0);
    end

    // Flush mid-operation abandons the request.
    start_req(64'h1, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_val("flush_in_ready", 64'(in_ready), 64'd1);
    check_val("flush_out_valid", 64'(out_valid), 64'd0);
    expect_quiet("flush", 8);

    // Flush in IDLE blocks a same-cycle request.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; shift_op = 3'b100; alu_32 = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush_block_in_ready", 64'(in_ready), 64'd1);
    expect_quiet("flush_block", 8);

    // Asynchronous reset mid-operation.
    run_op("pre_rst", 3'b100, 1'b0, 64'h5, 64'd2, 64'd20, 0);
    start_req(64'h3, 64'd3);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_result", shift_result, 64'd0);
    #7;
    rst = 1'b0;
    expect_quiet("rst", 8);
    run_op("post_rst", 3'b001, 1'b1, 64'h00000000F0000000, 64'd8, 64'hFFFFFFFFFFF00000, 0);

    check_val("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
